// File: rtl/mfp_ahb_lite_arbiter.sv
// N-master AHB-Lite arbiter in front of mfp_ahb.
// Address and data phases have separate owners so handovers stay on transfer boundaries.
module mfp_ahb_lite_arbiter #(
    parameter int N_MASTERS     = 2,
    parameter int PRIORITY_MODE = 0,
    parameter int PARK_MASTER   = 0,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [N_MASTERS-1:0]          M_REQ,
    output logic [N_MASTERS-1:0]          M_GRANT,
    input  logic [N_MASTERS*ADDR_W-1:0]   M_HADDR,
    input  logic [N_MASTERS*2-1:0]        M_HTRANS,
    input  logic [N_MASTERS-1:0]          M_HWRITE,
    input  logic [N_MASTERS*3-1:0]        M_HSIZE,
    input  logic [N_MASTERS*3-1:0]        M_HBURST,
    input  logic [N_MASTERS*4-1:0]        M_HPROT,
    input  logic [N_MASTERS-1:0]          M_HMASTLOCK,
    input  logic [N_MASTERS*DATA_W-1:0]   M_HWDATA,
    output logic [N_MASTERS-1:0]          M_HREADY,
    output logic [N_MASTERS-1:0]          M_HRESP,
    output logic [DATA_W-1:0]             M_HRDATA,
    output logic [ADDR_W-1:0]             S_HADDR,
    output logic [1:0]                    S_HTRANS,
    output logic                          S_HWRITE,
    output logic [2:0]                    S_HSIZE,
    output logic [2:0]                    S_HBURST,
    output logic [3:0]                    S_HPROT,
    output logic                          S_HMASTLOCK,
    output logic [DATA_W-1:0]             S_HWDATA,
    input  logic [DATA_W-1:0]             S_HRDATA,
    input  logic                          S_HREADY,
    input  logic                          S_HRESP,
    output logic [2:0]                    OWNER
);

    localparam logic [2:0] PARK = 3'(PARK_MASTER);

    logic [2:0] owner;
    logic [2:0] data_owner;
    logic [2:0] rr_ptr;
    logic [2:0] winner;
    logic       found;
    logic       window;

    // Address/control follow the address-phase owner
    always_comb begin
        S_HADDR     = '0;
        S_HTRANS    = 2'b00;
        S_HWRITE    = 1'b0;
        S_HSIZE     = 3'b000;
        S_HBURST    = 3'b000;
        S_HPROT     = 4'b0000;
        S_HMASTLOCK = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner == 3'(i)) begin
                S_HADDR     = M_HADDR[i*ADDR_W +: ADDR_W];
                S_HTRANS    = M_HTRANS[i*2 +: 2];
                S_HWRITE    = M_HWRITE[i];
                S_HSIZE     = M_HSIZE[i*3 +: 3];
                S_HBURST    = M_HBURST[i*3 +: 3];
                S_HPROT     = M_HPROT[i*4 +: 4];
                S_HMASTLOCK = M_HMASTLOCK[i];
            end
        end
    end

    // Write data follows whoever owns the data phase
    always_comb begin
        S_HWDATA = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (data_owner == 3'(i)) begin
                S_HWDATA = M_HWDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        M_GRANT  = '0;
        M_HREADY = '0;
        M_HRESP  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            M_GRANT[i]  = (owner == 3'(i));
            M_HREADY[i] = S_HREADY &
                          ((owner == 3'(i)) | (data_owner == 3'(i)));
            M_HRESP[i]  = S_HRESP & (data_owner == 3'(i));
        end
    end

    assign M_HRDATA = S_HRDATA;
    assign OWNER    = owner;

    assign window = S_HREADY & (S_HTRANS == 2'b00) & ~S_HMASTLOCK;

    // Fixed: lowest index wins. Round-robin: scan from rr_ptr+1 with wrap.
    always_comb begin
        winner = PARK;
        found  = 1'b0;
        if (PRIORITY_MODE == 0) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (M_REQ[i]) begin
                    winner = 3'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= N_MASTERS; k++) begin
                for (int i = 0; i < N_MASTERS; i++) begin
                    if (!found && M_REQ[i] &&
                        i == (int'(rr_ptr) + k) % N_MASTERS) begin
                        winner = 3'(i);
                        found  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner      <= PARK;
            data_owner <= PARK;
            rr_ptr     <= PARK;
        end else begin
            if (S_HREADY) begin
                data_owner <= owner;
            end
            if (window) begin
                owner <= winner;
                if (winner != owner) begin
                    rr_ptr <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_mfp_ahb_lite_arbiter.sv
// Directed bench: 2-master fixed-priority arbiter plus 4-master round-robin arbiter.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_mfp_ahb_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic [63:0] haddr;
    logic [3:0]  htrans;
    logic [1:0]  hwrite;
    logic [5:0]  hsize;
    logic [5:0]  hburst;
    logic [7:0]  hprot;
    logic [1:0]  lock;
    logic [63:0] hwdata;
    logic [1:0]  m_hready;
    logic [1:0]  m_hresp;
    logic [31:0] m_hrdata;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic [3:0]  s_hprot;
    logic        s_hmastlock;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;
    logic [2:0]  owner;

    mfp_ahb_lite_arbiter #(
        .N_MASTERS(2), .PRIORITY_MODE(0), .PARK_MASTER(0),
        .ADDR_W(32), .DATA_W(32)
    ) u_dut (
        .HCLK(clk), .HRESET(rst),
        .M_REQ(req), .M_GRANT(grant),
        .M_HADDR(haddr), .M_HTRANS(htrans), .M_HWRITE(hwrite),
        .M_HSIZE(hsize), .M_HBURST(hburst), .M_HPROT(hprot),
        .M_HMASTLOCK(lock), .M_HWDATA(hwdata),
        .M_HREADY(m_hready), .M_HRESP(m_hresp), .M_HRDATA(m_hrdata),
        .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite),
        .S_HSIZE(s_hsize), .S_HBURST(s_hburst), .S_HPROT(s_hprot),
        .S_HMASTLOCK(s_hmastlock), .S_HWDATA(s_hwdata),
        .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
        .OWNER(owner)
    );

    logic [3:0]   r_req;
    logic [3:0]   r_grant;
    logic [127:0] r_haddr;
    logic [7:0]   r_htrans;
    logic [3:0]   r_hwrite;
    logic [11:0]  r_hsize;
    logic [11:0]  r_hburst;
    logic [15:0]  r_hprot;
    logic [3:0]   r_lock;
    logic [127:0] r_hwdata;
    logic [3:0]   r_m_hready;
    logic [3:0]   r_m_hresp;
    logic [31:0]  r_m_hrdata;
    logic [31:0]  r_s_haddr;
    logic [1:0]   r_s_htrans;
    logic         r_s_hwrite;
    logic [2:0]   r_s_hsize;
    logic [2:0]   r_s_hburst;
    logic [3:0]   r_s_hprot;
    logic         r_s_hmastlock;
    logic [31:0]  r_s_hwdata;
    logic [2:0]   r_owner;

    mfp_ahb_lite_arbiter #(
        .N_MASTERS(4), .PRIORITY_MODE(1), .PARK_MASTER(0),
        .ADDR_W(32), .DATA_W(32)
    ) u_rr (
        .HCLK(clk), .HRESET(rst),
        .M_REQ(r_req), .M_GRANT(r_grant),
        .M_HADDR(r_haddr), .M_HTRANS(r_htrans), .M_HWRITE(r_hwrite),
        .M_HSIZE(r_hsize), .M_HBURST(r_hburst), .M_HPROT(r_hprot),
        .M_HMASTLOCK(r_lock), .M_HWDATA(r_hwdata),
        .M_HREADY(r_m_hready), .M_HRESP(r_m_hresp), .M_HRDATA(r_m_hrdata),
        .S_HADDR(r_s_haddr), .S_HTRANS(r_s_htrans), .S_HWRITE(r_s_hwrite),
        .S_HSIZE(r_s_hsize), .S_HBURST(r_s_hburst), .S_HPROT(r_s_hprot),
        .S_HMASTLOCK(r_s_hmastlock), .S_HWDATA(r_s_hwdata),
        .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
        .OWNER(r_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; haddr = '0; htrans = '0; hwrite = '0;
        hsize = '0; hburst = '0; hprot = '0; lock = '0; hwdata = '0;
        r_req = '0; r_haddr = '0; r_htrans = '0; r_hwrite = '0;
        r_hsize = '0; r_hburst = '0; r_hprot = '0; r_lock = '0;
        r_hwdata = '0;
        s_hrdata = 32'h0; s_hready = 1'b1; s_hresp = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 2'b01)
            $display("FAIL reset_grant got=%b want=01", grant);
        else passed++;
        total++;
        if (owner !== 3'd0)
            $display("FAIL reset_owner got=%0d want=0", owner);
        else passed++;
        total++;
        if (r_grant !== 4'b0001)
            $display("FAIL rr_reset_grant got=%b want=0001", r_grant);
        else passed++;
    endtask

    task automatic test_write();
        step();
        haddr[31:0] = 32'hBF80_0000;
        htrans[1:0] = 2'b10;
        hwrite[0]   = 1'b1;
        hsize[2:0]  = 3'b010;
        @(negedge clk);
        total++;
        if (s_haddr !== 32'hBF80_0000 || s_htrans !== 2'b10 || !s_hwrite)
            $display("FAIL write_addr got=%h/%b want=bf800000/10",
                     s_haddr, s_htrans);
        else passed++;
        step();
        htrans[1:0]  = 2'b00;
        hwrite[0]    = 1'b0;
        hwdata[31:0] = 32'h1234_5678;
        s_hrdata     = 32'h5A5A_0101;
        @(negedge clk);
        total++;
        if (s_hwdata !== 32'h1234_5678)
            $display("FAIL write_data got=%h want=12345678", s_hwdata);
        else passed++;
        total++;
        if (m_hready !== 2'b01)
            $display("FAIL write_hready got=%b want=01", m_hready);
        else passed++;
        total++;
        if (m_hrdata !== 32'h5A5A_0101)
            $display("FAIL hrdata_bcast got=%h want=5a5a0101", m_hrdata);
        else passed++;
    endtask

    task automatic test_fixed_priority();
        step();
        req = 2'b11;
        @(negedge clk);
        total++;
        if (grant !== 2'b01)
            $display("FAIL fixed_both_a got=%b want=01", grant);
        else passed++;
        step();
        req = 2'b10;
        @(negedge clk);
        total++;
        if (grant !== 2'b01)
            $display("FAIL fixed_both_b got=%b want=01", grant);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if (grant !== 2'b10 || owner !== 3'd1)
            $display("FAIL fixed_handover got=%b/%0d want=10/1",
                     grant, owner);
        else passed++;
        total++;
        if (m_hready !== 2'b11)
            $display("FAIL handover_hready got=%b want=11", m_hready);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if (m_hready !== 2'b10)
            $display("FAIL settled_hready got=%b want=10", m_hready);
        else passed++;
    endtask

    task automatic test_burst();
        logic [31:0] dat [4];
        dat[0] = 32'hA000_0001;
        dat[1] = 32'hA000_0002;
        dat[2] = 32'hA000_0003;
        dat[3] = 32'hA000_0004;
        step();
        req = 2'b01;
        step();
        htrans[1:0] = 2'b10;
        hburst[2:0] = 3'b011;
        hwrite[0]   = 1'b1;
        haddr[31:0] = 32'h0000_0100;
        req         = 2'b10;
        @(negedge clk);
        total++;
        if (grant !== 2'b01)
            $display("FAIL burst_beat1 got=%b want=01", grant);
        else passed++;
        for (int b = 1; b < 4; b++) begin
            step();
            htrans[1:0]  = 2'b11;
            haddr[31:0]  = 32'h0000_0100 + 32'(b * 4);
            hwdata[31:0] = dat[b-1];
            @(negedge clk);
            total++;
            if (grant !== 2'b01)
                $display("FAIL burst_seq%0d got=%b want=01", b, grant);
            else passed++;
        end
        step();
        htrans[1:0]  = 2'b00;
        hwrite[0]    = 1'b0;
        hwdata[31:0] = dat[3];
        @(negedge clk);
        total++;
        if (grant !== 2'b01)
            $display("FAIL burst_idle got=%b want=01", grant);
        else passed++;
        step();
        htrans[3:2]  = 2'b10;
        hwrite[1]    = 1'b1;
        haddr[63:32] = 32'h0000_0200;
        @(negedge clk);
        total++;
        if (grant !== 2'b10)
            $display("FAIL burst_grant got=%b want=10", grant);
        else passed++;
        total++;
        if (s_hwdata !== 32'hA000_0004 || s_haddr !== 32'h0000_0200)
            $display("FAIL burst_overlap got=%h/%h want=a0000004/00000200",
                     s_hwdata, s_haddr);
        else passed++;
        step();
        htrans[3:2]   = 2'b00;
        hwrite[1]     = 1'b0;
        hwdata[63:32] = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if (s_hwdata !== 32'hCAFE_F00D)
            $display("FAIL m1_wdata got=%h want=cafef00d", s_hwdata);
        else passed++;
    endtask

    task automatic test_lock();
        logic [1:0] tr [4];
        logic       lk [4];
        tr[0] = 2'b10; lk[0] = 1'b1;
        tr[1] = 2'b00; lk[1] = 1'b1;
        tr[2] = 2'b10; lk[2] = 1'b1;
        tr[3] = 2'b00; lk[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            req         = 2'b11;
            htrans[3:2] = tr[c];
            lock[1]     = lk[c];
            @(negedge clk);
            total++;
            if (grant !== 2'b10)
                $display("FAIL lock_hold%0d got=%b want=10", c, grant);
            else passed++;
        end
        step();
        @(negedge clk);
        total++;
        if (grant !== 2'b01)
            $display("FAIL lock_release got=%b want=01", grant);
        else passed++;
    endtask

    task automatic test_stall_reset();
        step();
        req      = 2'b10;
        s_hready = 1'b0;
        s_hresp  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (grant !== 2'b01 || m_hready !== 2'b00)
                $display("FAIL stall%0d got=%b/%b want=01/00",
                         c, grant, m_hready);
            else passed++;
            step();
        end
        @(negedge clk);
        total++;
        if (m_hresp !== 2'b01)
            $display("FAIL stall_hresp got=%b want=01", m_hresp);
        else passed++;
        step();
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (owner !== 3'd0 || grant !== 2'b01)
            $display("FAIL post_reset got=%0d/%b want=0/01", owner, grant);
        else passed++;
        total++;
        if (m_hresp !== 2'b00)
            $display("FAIL post_reset_hresp got=%b want=00", m_hresp);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_own [5];
        exp_own[0] = 3'd1;
        exp_own[1] = 3'd2;
        exp_own[2] = 3'd3;
        exp_own[3] = 3'd0;
        exp_own[4] = 3'd1;
        req = 2'b00;
        step();
        r_req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            total++;
            if (r_owner !== exp_own[c] ||
                r_grant !== (4'b0001 << exp_own[c]))
                $display("FAIL rr_seq%0d got=%0d/%b want=%0d",
                         c, r_owner, r_grant, exp_own[c]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_fixed_priority();
        test_burst();
        test_lock();
        test_stall_reset();
        test_round_robin();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
